hidden_cpu_fetch: RTL

//  Instruction-fetch stage directly upstream of the 8-bit HiddenCPU core.
//  - Program load: takes 6-bit instructions {opcode[1:0], reg0Addr[1:0], reg1Addr[1:0]} over a valid/ready port into a small program store.
//  - Run: streams instructions to the core, indexed by the core's PC, and holds the core in reset outside RUN.
//  - Halts cleanly when the PC leaves the loaded program.

---
 rtl/hidden_cpu_pkg.sv | 33 +++
 rtl/hidden_cpu_prog_mem.sv | 25 ++
 rtl/hidden_cpu_fetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/hidden_cpu_pkg.sv
// Shared types and constants for the HiddenCPU instruction-fetch stage.
// Instruction layout is {opcode[1:0], reg0Addr[1:0], reg1Addr[1:0]}.
package hidden_cpu_pkg;

    localparam int unsigned IW = 6;
    localparam logic [IW-1:0] NOP_INSTR = 6'h00;

    // Fetch FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_LOAD = 2'd1;
    localparam state_t S_RUN  = 2'd2;
    localparam state_t S_HALT = 2'd3;

    // Decode field positions within an instruction word
    localparam int unsigned OPC_MSB = 5;
    localparam int unsigned OPC_LSB = 4;
    localparam int unsigned RA_MSB  = 3;
    localparam int unsigned RA_LSB  = 2;
    localparam int unsigned RB_MSB  = 1;
    localparam int unsigned RB_LSB  = 0;

    typedef struct packed {
        logic [1:0] opc;
        logic [1:0] ra;
        logic [1:0] rb;
    } instr_t;

    function automatic instr_t to_instr(input logic [IW-1:0] word);
        return instr_t'(word);
    endfunction

endpackage

// File: rtl/hidden_cpu_prog_mem.sv
// Program store: DEPTH x IW register array, one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
module hidden_cpu_prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 6
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [IW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [IW-1:0]            rdata
);

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hidden_cpu_fetch.sv
// Instruction-fetch stage for the HiddenCPU core: loads a program over a
// valid/ready port, then streams it by PC and halts when the PC leaves it.
module hidden_cpu_fetch
    import hidden_cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PCW   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   load_done,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [IW-1:0]          load_data,
    input  logic                   run,
    input  logic [PCW-1:0]         pc_in,
    output logic [IW-1:0]          instr_out,
    output logic                   cpu_rst,
    output logic                   halted,
    output logic [$clog2(DEPTH):0] prog_len
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LENW = AW + 1;
    localparam int unsigned CMPW = (PCW > LENW) ? PCW : LENW;

    state_t            state;
    state_t            next_state;
    logic [LENW-1:0]   wptr;
    logic              accept;
    logic              last_write;
    logic              load_end;
    logic              pc_ok;
    logic [IW-1:0]     rdata;

    // A restart in LOAD drops that cycle's data
    assign accept     = (state == S_LOAD) && !load_start && load_valid && load_ready;
    assign last_write = accept && (wptr == LENW'(DEPTH - 1));
    assign load_end   = (state == S_LOAD) && !load_start && (last_write || load_done);

    // Full-width compare so any wrapped PC beyond the program halts
    assign pc_ok = CMPW'(pc_in) < CMPW'(prog_len);

    hidden_cpu_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wptr[AW-1:0]),
        .wdata (load_data),
        .raddr (pc_in[AW-1:0]),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; load_start outranks run in IDLE/HALT
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    next_state = S_LOAD;
                end else if (run && (prog_len != '0)) begin
                    next_state = S_RUN;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    next_state = S_LOAD;
                end else if (last_write || load_done) begin
                    next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (!pc_ok) begin
                    next_state = S_HALT;
                end
            end
            S_HALT: begin
                if (load_start) begin
                    next_state = S_LOAD;
                end else if (run) begin
                    next_state = S_RUN;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Control outputs decoded from the registered state only
    always_comb begin
        cpu_rst    = 1'b1;
        halted     = 1'b0;
        load_ready = 1'b0;
        case (state)
            S_LOAD: load_ready = (wptr < LENW'(DEPTH));
            S_RUN:  cpu_rst    = 1'b0;
            S_HALT: halted     = 1'b1;
            default: ;
        endcase
    end

    // Write pointer and latched program length
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            prog_len <= '0;
        end else begin
            if (load_start && (state != S_RUN)) begin
                wptr <= '0;
            end else if (accept) begin
                wptr <= wptr + LENW'(1);
            end
            if (load_end) begin
                prog_len <= wptr + LENW'(accept);
            end
        end
    end

    // Registered instruction to the core; NOP outside a valid RUN fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out <= NOP_INSTR;
        end else if ((state == S_RUN) && pc_ok) begin
            instr_out <= rdata;
        end else begin
            instr_out <= NOP_INSTR;
        end
    end

endmodule
